// File: rtl/sequence_1001.sv
// sequence_1001: Moore detector for the serial pattern 1-0-0-1 with overlapping
// matches. The out flag is registered and is high only while the FSM sits in
// S_HIT.
// Optional feature macro: SEQ1001_COUNT_EN adds the saturating match_count port.
module sequence_1001 #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
`ifdef SEQ1001_COUNT_EN
  output logic [COUNT_W-1:0] match_count,
`endif
  output logic               out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_100  = 3'd3,
    S_HIT  = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   out_q, out_d;

  // Reject a zero-width counter at elaboration
  if (COUNT_W < 1) begin : g_bad_count_w
    $error("sequence_1001: COUNT_W must be at least 1");
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic; the flag is the registered decode of the next state
  always_comb begin
    state_d = S_IDLE;
    out_d   = 1'b0;
    unique case (state_q)
      S_IDLE:  state_d = x ? S_1   : S_IDLE;
      S_1:     state_d = x ? S_1   : S_10;
      S_10:    state_d = x ? S_1   : S_100;
      S_100:   state_d = x ? S_HIT : S_IDLE;
      // The trailing 1 of a match is the leading 1 of the next one
      S_HIT:   state_d = x ? S_1   : S_10;
      default: state_d = S_IDLE;
    endcase
    out_d = (state_d == S_HIT);
  end

  assign out = out_q;

`ifdef SEQ1001_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  // Saturating count of entries into S_HIT
  always_comb begin
    count_d = count_q;
    if ((state_d == S_HIT) && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Match counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_sequence_1001.sv
// Self-checking bench for sequence_1001: a history-based reference model
// (last four sampled bits since reset) checked every cycle, plus directed
// literal expectations. Exercises the counter when SEQ1001_COUNT_EN is defined.
module tb_sequence_1001;

`ifdef SEQ1001_COUNT_EN
  localparam int unsigned TB_COUNT_W = 2;
`else
  localparam int unsigned TB_COUNT_W = 8;
`endif
  localparam int MAXC = (1 << TB_COUNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic x;
  logic out;
`ifdef SEQ1001_COUNT_EN
  logic [TB_COUNT_W-1:0] match_count;
`endif

  int vectors = 0;
  int errors  = 0;

  // Reference model state: bits sampled since reset
  logic [3:0] hist = 4'b0000;
  int         nbits = 0;
  int         exp_count = 0;
  bit         chk_en = 1'b0;

  sequence_1001 #(.COUNT_W(TB_COUNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
`ifdef SEQ1001_COUNT_EN
    .match_count (match_count),
`endif
    .out         (out)
  );

  always #5 clk = ~clk;

  function automatic logic exp_out();
    return (nbits >= 4) && (hist == 4'b1001);
  endfunction

  // Reference model: a match is simply "last four samples were 1,0,0,1"
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist      = 4'b0000;
      nbits     = 0;
      exp_count = 0;
    end else begin
      hist = {hist[2:0], x};
      if (nbits < 4) nbits++;
      if (exp_out() && exp_count < MAXC) exp_count++;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (out !== exp_out()) begin
        errors++;
        $display("FAIL model_out t=%0t actual=%b required=%b", $time, out, exp_out());
      end
`ifdef SEQ1001_COUNT_EN
      vectors++;
      if (match_count !== TB_COUNT_W'(exp_count)) begin
        errors++;
        $display("FAIL model_count t=%0t actual=%0d required=%0d", $time, match_count, exp_count);
      end
`endif
    end
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
    end
  endtask

  task automatic check_cnt(input string name, input int req);
`ifdef SEQ1001_COUNT_EN
    vectors++;
    if (match_count !== TB_COUNT_W'(req)) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, match_count, req);
    end
`endif
  endtask

  // All stepping tasks are entered and left at a falling edge
  task automatic step(input logic b);
    x = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_chk(input string name, input logic b, input logic req);
    x = b;
    @(posedge clk);
    #1 check_bit(name, out, req);
    @(negedge clk);
  endtask

  // Reset asserted between edges, checked before the next edge, released at negedge
  task automatic pulse_reset();
    #3 reset = 1'b1;
    #1;
    check_bit("async_reset_out", out, 1'b0);
    check_cnt("async_reset_count", 0);
    @(negedge clk);
    reset = 1'b0;
    x     = 1'b0;
  endtask

  // Apply n bits MSB-first; only the final bit's output is checked literally
  task automatic run_stream(input string name, input logic [15:0] bits, input int n,
                            input logic req_last);
    for (int i = n - 1; i > 0; i--) step(bits[i]);
    step_chk(name, bits[0], req_last);
  endtask

  logic [11:0] dir_bits = 12'b1001_0010_1001;
  logic [11:0] dir_exp  = 12'b0001_0010_0001;

  initial begin
    reset = 1'b1;
    x     = 1'b0;
    #2 check_bit("reset_out", out, 1'b0);
    check_cnt("reset_count", 0);
    chk_en = 1'b1;
    @(negedge clk);            // 10 ns
    reset = 1'b0;
    step_chk("first_edge_idle", 1'b0, 1'b0);   // sampled at 15 ns
    // 25..135 ns: single match, overlap, non-match and recovery
    for (int i = 11; i >= 0; i--) step_chk("directed", dir_bits[i], dir_exp[i]);
    check_cnt("directed_count", 3);

    // Near-misses
    pulse_reset();
    run_stream("near_10001", 16'b1_0001, 5, 1'b0);
    pulse_reset();
    run_stream("near_101001", 16'b10_1001, 6, 1'b1);
    pulse_reset();
    run_stream("near_11001", 16'b1_1001, 5, 1'b1);

    // Reset while out is high, and reset while in S_100 discards the prefix
    pulse_reset();
    run_stream("pre_reset_hit", 16'b1001, 4, 1'b1);
    pulse_reset();
    run_stream("into_s100", 16'b100, 3, 1'b0);
    pulse_reset();
    step_chk("prefix_discarded", 1'b1, 1'b0);

    // Five overlapping matches saturate a 2-bit counter at 3
    pulse_reset();
    run_stream("five_matches", 16'b1001_0010_0100_1001, 16, 1'b1);
    check_cnt("count_saturated", 3);

    // Randomised stream with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else step(1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
